vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates 640x480 @ 60 Hz VGA timing from the 100 MHz system clock. Presents the current pixel address (ADDRH/ADDRV) to the game renderer, captures the renderer's COLOUR reply, and drives the blanked colour plus HS/VS to the DAC/connector pins. It is the display-side end of the ADDRH/ADDRV → COLOUR interface. It also emits a once-per-frame tick for game-clock derivation.

## Interface
Parameters:
- CLK_DIV, 4, CLK cycles per pixel (≥2)
- H_ACTIVE, 640; H_FP, 16; H_SYNC, 96; H_BP, 48 — horizontal pixels
- V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33 — vertical lines

Ports:
- CLK  in  1  system clock, 100 MHz
- RESET  in  1  synchronous, active-high
- COLOUR_IN  in  8  renderer colour for presented address, RRRGGGBB
- ADDRH  out  10  horizontal pixel address, 0..H_ACTIVE-1
- ADDRV  out  9  vertical pixel address, 0..V_ACTIVE-1
- COLOUR_OUT  out  8  colour to DAC, 0 during blanking
- HS  out  1  horizontal sync, active-low
- VS  out  1  vertical sync, active-low
- FRAME_TICK  out  1  one-CLK pulse on entry to vertical blank
- PIXEL_EN  out  1  one-CLK strobe per pixel period

## Operation
- Divider counter DIV counts 0..CLK_DIV-1 and wraps. PIXEL_EN is high while DIV == CLK_DIV-1.
- HCNT counts 0..H_TOTAL-1, where H_TOTAL = sum of the H params = 800. VCNT counts 0..V_TOTAL-1, where V_TOTAL = 525.
- Both counters advance only on PIXEL_EN edges. HCNT wraps to 0 and increments VCNT; VCNT wraps to 0 after V_TOTAL-1.
- Active region: HCNT < H_ACTIVE and VCNT < V_ACTIVE.
- ADDRH = HCNT when HCNT < H_ACTIVE, else 0. ADDRV = VCNT when VCNT < V_ACTIVE, else 0. Both are combinational from the counters and stable for the full CLK_DIV cycles of a pixel period.
- All of the following are registered on each PIXEL_EN edge, evaluated using the pre-advance counter values:
  - COLOUR_OUT <= active ? COLOUR_IN : 0
  - HS <= ~(H_ACTIVE+H_FP ≤ HCNT < H_ACTIVE+H_FP+H_SYNC), i.e. low for HCNT 656..751
  - VS <= ~(V_ACTIVE+V_FP ≤ VCNT < V_ACTIVE+V_FP+V_SYNC), i.e. low for VCNT 490..491
- FRAME_TICK is registered high for exactly one CLK, on the PIXEL_EN edge where HCNT = H_TOTAL-1 and VCNT = V_ACTIVE-1. It is low otherwise.
- Counter comparisons use 10-bit unsigned arithmetic; there is no signed logic.

## Timing
- Reset values: DIV=0, HCNT=0, VCNT=0, ADDRH=0, ADDRV=0, COLOUR_OUT=0, HS=1, VS=1, FRAME_TICK=0, PIXEL_EN=0.
- First PIXEL_EN occurs CLK_DIV cycles after RESET deasserts.
- Renderer latency budget: COLOUR_IN must be valid by the final CLK of the pixel period. This allows up to CLK_DIV-1 cycles of registered renderer latency.
- Output latency: the pixel at (h,v) appears on COLOUR_OUT exactly one pixel period after its address is first presented. HS/VS carry the same one-pixel delay, so colour and syncs stay aligned.
- Line period = 800×CLK_DIV CLK. Frame period = 420000×CLK_DIV CLK, which is 1,680,000 at the defaults.
- RESET mid-frame: all state returns to reset values on the next edge and the frame restarts at (0,0). No partial sync pulse is extended.
- COLOUR_IN is ignored outside the active region, including at HCNT = 640..799 of active lines.

## Configuration
- VGA_BORDER_EN defined: during active pixels where HCNT∈{0, H_ACTIVE-1} or VCNT∈{0, V_ACTIVE-1}, COLOUR_OUT is forced to 8'b00111000, overriding COLOUR_IN. Latency is unchanged.
- VGA_BORDER_EN undefined: no override; COLOUR_OUT follows COLOUR_IN in the active region.

## Test plan
- RESET held 5 cycles, then released → all outputs at reset values during reset. PIXEL_EN first high at cycle 4 after release, then every 4 cycles.
- Run 1 line → HS low for exactly 96×4 = 384 CLK. The falling edge occurs one pixel period after HCNT reaches 656. ADDRH sweeps 0..639, then holds 0 for HCNT 640..799.
- Run 1 frame → VS low for exactly 2 lines = 6400 CLK, starting on line 490. FRAME_TICK fires once per 1,680,000 CLK and is 1 CLK wide.
- Drive COLOUR_IN = {ADDRH[7:0]} → COLOUR_OUT shows ADDRH-1 pattern one pixel later, is 0 throughout horizontal and vertical blanking, and 8'hFF is never seen at HCNT ≥ 640.
- Assert RESET for 1 CLK at VCNT=200, HCNT=300 → next cycle HCNT=VCNT=0, HS=VS=1, COLOUR_OUT=0. Timing then resumes from (0,0).
- With VGA_BORDER_EN and COLOUR_IN=8'h07 → COLOUR_OUT=8'h38 at (0,y), (639,y), (x,0) and (x,479); 8'h07 elsewhere in the active region. Without the macro, 8'h07 everywhere in the active region.

Source files
------------

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_timing_gen : VGA raster timing, pixel address to renderer, blanked colour
// and HS/VS to the DAC. Build macro VGA_BORDER_EN adds a 1-pixel border. Rev 1.0
// ----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] COLOUR_IN,
  output logic [9:0] ADDRH,
  output logic [8:0] ADDRV,
  output logic [7:0] COLOUR_OUT,
  output logic       HS,
  output logic       VS,
  output logic       FRAME_TICK,
  output logic       PIXEL_EN
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_ACT        = 10'(H_ACTIVE);
  localparam logic [9:0] H_ACT_LAST   = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] HS_START     = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END       = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_ACT        = 10'(V_ACTIVE);
  localparam logic [9:0] V_ACT_LAST   = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] VS_START     = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END       = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div;
  logic [9:0]       hcnt;
  logic [9:0]       vcnt;
  logic             h_active;
  logic             v_active;
  logic             active;
  logic [7:0]       pixel_colour;

  assign PIXEL_EN = (div == DIV_LAST);
  assign h_active = (hcnt < H_ACT);
  assign v_active = (vcnt < V_ACT);
  assign active   = h_active && v_active;
  assign ADDRH    = h_active ? hcnt : '0;
  assign ADDRV    = v_active ? vcnt[8:0] : '0;

`ifdef VGA_BORDER_EN
  logic border;
  // Only meaningful inside the active region; blanking masks it below.
  assign border = (hcnt == '0) || (hcnt == H_ACT_LAST) ||
                  (vcnt == '0) || (vcnt == V_ACT_LAST);
  assign pixel_colour = border ? 8'b0011_1000 : COLOUR_IN;
`else
  assign pixel_colour = COLOUR_IN;
`endif

  // Outputs are captured from the pre-advance counters, giving one pixel of
  // latency shared by colour and both syncs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      div        <= '0;
      hcnt       <= '0;
      vcnt       <= '0;
      COLOUR_OUT <= '0;
      HS         <= 1'b1;
      VS         <= 1'b1;
      FRAME_TICK <= 1'b0;
    end else begin
      FRAME_TICK <= PIXEL_EN && (hcnt == H_LAST) && (vcnt == V_ACT_LAST);
      if (PIXEL_EN) begin
        div        <= '0;
        COLOUR_OUT <= active ? pixel_colour : '0;
        HS         <= !((hcnt >= HS_START) && (hcnt < HS_END));
        VS         <= !((vcnt >= VS_START) && (vcnt < VS_END));
        if (hcnt == H_LAST) begin
          hcnt <= '0;
          vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
        end else begin
          hcnt <= hcnt + 10'd1;
        end
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// tb_vga_timing_gen : scoreboard bench; full 800-pixel lines with a short
// 8-line frame so several frames fit in a short run.
module tb_vga_timing_gen;

  localparam int CLK_DIV = 4;
  localparam int HA  = 640, HFP = 16, HSY = 96, HBP = 48;
  localparam int VA  = 4,   VFP = 1,  VSY = 2,  VBP = 1;
  localparam int HT  = HA + HFP + HSY + HBP;
  localparam int VT  = VA + VFP + VSY + VBP;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] colour_in = 8'h00;
  logic [9:0] ADDRH;
  logic [8:0] ADDRV;
  logic [7:0] COLOUR_OUT;
  logic       HS, VS, FRAME_TICK, PIXEL_EN;

  vga_timing_gen #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
  ) dut (
    .CLK(CLK), .RESET(RESET), .COLOUR_IN(colour_in),
    .ADDRH(ADDRH), .ADDRV(ADDRV), .COLOUR_OUT(COLOUR_OUT),
    .HS(HS), .VS(VS), .FRAME_TICK(FRAME_TICK), .PIXEL_EN(PIXEL_EN)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [9:0] ah;
    logic [8:0] av;
    logic [7:0] col;
    logic       hs;
    logic       vs;
    logic       tick;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   tick_total = 0;

  // Reference model state: cycles since reset and outputs registered last pixel
  int         n = 0;
  bit         mode = 1'b0;
  logic [7:0] m_col  = 8'h00;
  logic       m_hs   = 1'b1;
  logic       m_vs   = 1'b1;
  logic       m_tick = 1'b0;

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
  endfunction

  task automatic step();
    int   p, h, v;
    exp_t e;
    logic act;
    if (n % CLK_DIV == 0) begin
      p = n / CLK_DIV;
      h = p % HT;
      v = (p / HT) % VT;
      e.ah   = (h < HA) ? 10'(h) : 10'd0;
      e.av   = (v < VA) ? 9'(v) : 9'd0;
      e.col  = m_col;
      e.hs   = m_hs;
      e.vs   = m_vs;
      e.tick = m_tick;
      exp_q.push_back(e);
      act = (h < HA) && (v < VA);
      if (!act)            m_col = 8'h00;
      else if (mode == 0)  m_col = 8'(h);
      else begin
`ifdef VGA_BORDER_EN
        m_col = (h == 0 || h == HA-1 || v == 0 || v == VA-1) ? 8'h38 : 8'h07;
`else
        m_col = 8'h07;
`endif
      end
      m_hs   = !(h >= HA+HFP && h < HA+HFP+HSY);
      m_vs   = !(v >= VA+VFP && v < VA+VFP+VSY);
      m_tick = (h == HT-1) && (v == VA-1);
    end
    colour_in = mode ? 8'h07 : ADDRH[7:0];
    n++;
  endtask

  task automatic run_to(int last_n);
    while (n <= last_n) begin
      @(negedge CLK);
      step();
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_addrh"},  ADDRH, 0);
    check({tag, "_addrv"},  ADDRV, 0);
    check({tag, "_colour"}, COLOUR_OUT, 0);
    check({tag, "_hs"},     HS, 1);
    check({tag, "_vs"},     VS, 1);
    check({tag, "_tick"},   FRAME_TICK, 0);
    check({tag, "_pixen"},  PIXEL_EN, 0);
  endtask

  // Monitor: pops one expected item per DUT pixel strobe; also measures
  // strobe spacing, sync pulse widths and tick width.
  initial begin
    int   cyc = 0, tick_cnt = 0, hs_run = 0, vs_run = 0;
    exp_t e;
    forever begin
      @(negedge CLK);
      #1;
      if (RESET) begin
        cyc = 0; tick_cnt = 0; hs_run = 0; vs_run = 0;
      end else begin
        cyc++;
        if (FRAME_TICK) begin tick_cnt++; tick_total++; end
        if (!HS) hs_run++;
        else if (hs_run != 0) begin check("hs_width", hs_run, HSY*CLK_DIV); hs_run = 0; end
        if (!VS) vs_run++;
        else if (vs_run != 0) begin check("vs_width", vs_run, VSY*HT*CLK_DIV); vs_run = 0; end
        if (PIXEL_EN) begin
          check("pixel_en_period", cyc, CLK_DIV);
          cyc = 0;
          if (exp_q.size() == 0) check("queue_underflow", exp_q.size(), 1);
          else begin
            e = exp_q.pop_front();
            check("addrh",      ADDRH, e.ah);
            check("addrv",      ADDRV, e.av);
            check("colour_out", COLOUR_OUT, e.col);
            check("hs",         HS, e.hs);
            check("vs",         VS, e.vs);
            check("frame_tick", tick_cnt, e.tick ? 1 : 0);
          end
          tick_cnt = 0;
        end
      end
    end
  end

  initial begin
    RESET = 1'b1;
    repeat (5) @(negedge CLK);
    check_reset_outputs("reset");
    RESET = 1'b0;
    step();
    // Frame 1: renderer replies with ADDRH[7:0]
    run_to(HT*VT*CLK_DIV - 1);
    // Frame 2: constant colour, then reset mid-line inside both sync pulses
    mode = 1'b1;
    run_to(HT*VT*CLK_DIV + ((VA+VFP)*HT + 700)*CLK_DIV);
    @(negedge CLK);
    RESET = 1'b1;
    exp_q.delete();
    @(negedge CLK);
    RESET = 1'b0;
    check_reset_outputs("midreset");
    n = 0; m_col = 8'h00; m_hs = 1'b1; m_vs = 1'b1; m_tick = 1'b0;
    step();
    run_to(2*HT*CLK_DIV - 1);
    @(negedge CLK);
    #2;
    check("queue_drained", exp_q.size(), 0);
    check("tick_total", tick_total, 2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
